// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for the 16-bit Spartan CPU; decodes IR into
// register-file, PC, comparator, logic-unit and data-memory strobes.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_bus,
  input  logic [15:0] f_bus,
  input  logic        mem_ready,
  output logic        memory_read,
  output logic        memory_write,
  output logic        pc_increment,
  output logic        pc_load,
  output logic        cmp_load,
  output logic        cmp_compare,
  output logic        lu_passthrough,
  output logic        lu_add,
  output logic        lu_sub,
  output logic        lu_shr,
  output logic        lu_shl,
  output logic        lu_band,
  output logic        lu_bor,
  output logic        lu_bxor,
  output logic        lu_bnegate,
  output logic        reg1_read,
  output logic        reg2_read,
  output logic        reg3_write,
  output logic [3:0]  reg1_addr,
  output logic [3:0]  reg2_addr,
  output logic [3:0]  reg3_addr,
  output logic        halted
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, HALT = 3'd4;
  logic [2:0] state, state_nx;
  logic [15:0] ir;
  logic [3:0] op;
  logic dec, ex, mem, is_ld, is_st, is_cmp, is_alu, taken, jump, use_r1, use_r2;
  assign op = ir[15:12];
  assign reg1_addr = ir[11:8];
  assign reg2_addr = ir[7:4];
  assign reg3_addr = ir[3:0];
  assign dec = state == DECODE;
  assign ex = state == EXEC;
  assign mem = state == MEM;
  assign halted = state == HALT;
  assign is_ld = op == 4'hA;
  assign is_st = op == 4'hB;
  assign is_cmp = op == 4'hC;
  assign is_alu = op >= 4'd1 && op <= 4'd9;
  // An unknown flag must read as "not taken", so only an explicit 1 selects the jump.
  always_comb begin
    taken = 1'b0;
    if (f_bus[ir[7:4]]) taken = 1'b1;
  end
  assign jump = op == 4'hD || (op == 4'hE && taken);
  assign use_r1 = is_alu || is_st || is_cmp || op == 4'hD || op == 4'hE;
  assign use_r2 = (op >= 4'd2 && op <= 4'd8) || is_ld || is_st || (is_cmp && !ir[0]);
  always_comb
    state_nx = state == FETCH  ? DECODE :
               state == DECODE ? ((is_ld || is_st) ? MEM : op == 4'hF ? HALT : EXEC) :
               state == EXEC   ? FETCH :
               state == MEM    ? (mem_ready ? FETCH : MEM) : HALT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      ir <= 16'h0000;
    end else begin
      state <= state_nx;
      if (state == FETCH) ir <= i_bus;
    end
  assign memory_read = mem && is_ld;
  assign memory_write = mem && is_st;
  assign reg1_read = ((dec || ex) && use_r1) || (mem && is_st);
  assign reg2_read = ((dec || ex) && use_r2) || mem;
  assign reg3_write = (ex && is_alu) || (mem && is_ld && mem_ready);
  assign pc_load = ex && jump;
  assign pc_increment = (ex && !jump) || (mem && mem_ready);
  assign cmp_compare = ex && is_cmp && !ir[0];
  assign cmp_load = ex && is_cmp && ir[0];
  // ST drives its store data through the passthrough path for the whole MEM wait.
  assign lu_passthrough = (ex && (op == 4'h1 || jump)) || (mem && is_st);
  assign lu_add = ex && op == 4'h2;
  assign lu_sub = ex && op == 4'h3;
  assign lu_shr = ex && op == 4'h4;
  assign lu_shl = ex && op == 4'h5;
  assign lu_band = ex && op == 4'h6;
  assign lu_bor = ex && op == 4'h7;
  assign lu_bxor = ex && op == 4'h8;
  assign lu_bnegate = ex && op == 4'h9;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench; expected retire behaviour per instruction is
// queued by the driver and checked by a monitor whenever the DUT strobes the PC.
module tb_control_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] i_bus = 16'h0, f_bus = 16'h0;
  logic mem_ready = 1'b0;
  logic memory_read, memory_write, pc_increment, pc_load, cmp_load, cmp_compare;
  logic lu_passthrough, lu_add, lu_sub, lu_shr, lu_shl, lu_band, lu_bor, lu_bxor, lu_bnegate;
  logic reg1_read, reg2_read, reg3_write, halted;
  logic [3:0] reg1_addr, reg2_addr, reg3_addr;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .i_bus(i_bus), .f_bus(f_bus), .mem_ready(mem_ready),
    .memory_read(memory_read), .memory_write(memory_write),
    .pc_increment(pc_increment), .pc_load(pc_load),
    .cmp_load(cmp_load), .cmp_compare(cmp_compare),
    .lu_passthrough(lu_passthrough), .lu_add(lu_add), .lu_sub(lu_sub), .lu_shr(lu_shr),
    .lu_shl(lu_shl), .lu_band(lu_band), .lu_bor(lu_bor), .lu_bxor(lu_bxor),
    .lu_bnegate(lu_bnegate),
    .reg1_read(reg1_read), .reg2_read(reg2_read), .reg3_write(reg3_write),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg3_addr(reg3_addr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    logic [17:0] vec;
    logic [11:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0, cnt = 0;
  logic [17:0] vec;
  assign vec = {memory_read, memory_write, pc_increment, pc_load, cmp_load, cmp_compare,
                lu_passthrough, lu_add, lu_sub, lu_shr, lu_shl, lu_band, lu_bor, lu_bxor,
                lu_bnegate, reg1_read, reg2_read, reg3_write};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] pack(bit mr, bit mw, bit pi, bit pl, bit cl, bit cc,
                                       logic [8:0] lu, bit r1, bit r2, bit w);
    return {mr, mw, pi, pl, cl, cc, lu, r1, r2, w};
  endfunction

  // Architectural view: what each instruction does in the cycle it retires, and how long it takes.
  function automatic exp_t model(logic [15:0] ins, logic [15:0] f, int w);
    exp_t e;
    int op = int'(ins[15:12]);
    bit ld = op == 10;
    bit st = op == 11;
    bit cmp = op == 12;
    bit alu = op >= 1 && op <= 9;
    bit jmp = op == 13 || (op == 14 && f[ins[7:4]] == 1'b1);
    logic [8:0] lu = 9'h0;
    e.addr = ins[11:0];
    if (ld || st) begin
      e.len = 3 + w;
      e.vec = pack(ld, st, 1, 0, 0, 0, st ? 9'h100 : 9'h0, st, 1, ld);
    end else begin
      if (alu) lu = 9'h100 >> (op - 1);
      if (jmp) lu = 9'h100;
      e.len = 3;
      e.vec = pack(0, 0, !jmp, jmp, cmp && ins[0], cmp && !ins[0], lu,
                   alu || cmp || op == 13 || op == 14,
                   (op >= 2 && op <= 8) || (cmp && !ins[0]), alu);
    end
    return e;
  endfunction

  function automatic logic [17:0] dec_vec(logic [15:0] ins);
    int op = int'(ins[15:12]);
    bit r1 = (op >= 1 && op <= 9) || (op >= 11 && op <= 14);
    bit r2 = (op >= 2 && op <= 8) || op == 10 || op == 11 || (op == 12 && !ins[0]);
    return pack(0, 0, 0, 0, 0, 0, 9'h0, r1, r2, 0);
  endfunction

  // Entered and left at posedge+1, i.e. at the start of the FETCH cycle.
  task automatic run(logic [15:0] ins, logic [15:0] f, int w);
    exp_t e = model(ins, f, w);
    sb.push_back(e);
    i_bus = ins;
    f_bus = f;
    for (int j = 1; j <= e.len; j++) begin
      mem_ready = j >= 3 ? (j - 3 >= w) : 1'($urandom);
      if (j == 2) chk("decode_reads", 32'(vec), 32'(dec_vec(ins)));
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) cnt = 0;
    else begin
      cnt++;
      chk("pc_excl_lu_onehot", {30'h0, pc_increment & pc_load, $countones(vec[11:3]) > 1}, 0);
      if (pc_increment | pc_load) begin
        if (sb.size() == 0) chk("unexpected_retire", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("retire_len", cnt, mon_e.len);
          chk("retire_strobes", 32'(vec), 32'(mon_e.vec));
          chk("retire_addr", {20'h0, reg1_addr, reg2_addr, reg3_addr}, 32'(mon_e.addr));
        end
        cnt = 0;
      end else chk("idle_no_commit", {29'h0, reg3_write, cmp_load, cmp_compare}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ins;
    #12;
    chk("reset_strobes", 32'(vec), 0);
    chk("reset_addr", {20'h0, reg1_addr, reg2_addr, reg3_addr}, 0);
    chk("reset_halted", 32'(halted), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(16'h2123, 16'($urandom), 0);
    run(16'hA045, 16'($urandom), 2);
    run(16'hE230, 16'h0008, 0);
    run(16'hE230, 16'h0000, 0);
    run(16'hC120, 16'($urandom), 0);
    run(16'hC101, 16'($urandom), 0);
    for (int n = 0; n < 60; n++) begin
      do ins = 16'($urandom); while (ins[15:12] == 4'hF);
      run(ins, 16'($urandom), int'($urandom_range(0, 3)));
    end
    i_bus = 16'hB010;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("st_wait_write", 32'(memory_write), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_write", 32'(memory_write), 0);
    chk("async_reset_strobes", 32'(vec), 0);
    chk("async_reset_addr", {20'h0, reg1_addr, reg2_addr, reg3_addr}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(16'h2123, 16'($urandom), 0);
    run(16'hB010, 16'($urandom), 1);
    i_bus = 16'hF000;
    @(posedge clk);
    #1;
    chk("hlt_decode_not_halted", 32'(halted), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      mem_ready = k[0];
      chk("halted", 32'(halted), 1);
      chk("halt_quiet", 32'(vec), 0);
      @(posedge clk);
      #1;
    end
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 16-bit Spartan CPU: latches the word on `i_bus`, decodes it, and drives every strobe and register address that the register file, program counter, comparator and logic unit consume. It sits between instruction memory and the datapath, and is the only block that advances the program counter. It runs a multi-cycle FSM with a wait-state handshake toward data memory.

## Interface
Parameters: none.

- `clk` in 1: system clock; all state changes on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `i_bus` in 16: instruction word addressed by the PC
- `f_bus` in 16: comparator flags
- `mem_ready` in 1: data memory has completed the current read or write
- `memory_read`, `memory_write` out 1: data memory strobes
- `pc_increment`, `pc_load` out 1: program counter strobes; never both high in the same cycle
- `cmp_load`, `cmp_compare` out 1: comparator strobes
- `lu_passthrough`, `lu_add`, `lu_sub`, `lu_shr`, `lu_shl`, `lu_band`, `lu_bor`, `lu_bxor`, `lu_bnegate` out 1: logic unit op select; at most one high at a time
- `reg1_read`, `reg2_read`, `reg3_write` out 1: register file port enables
- `reg1_addr`, `reg2_addr`, `reg3_addr` out 4: register file port addresses
- `halted` out 1: high while in HALT

## Operation
- Instruction register (IR) fields: op = [15:12], a = [11:8], b = [7:4], c = [3:0].
- Address outputs always mirror IR: `reg1_addr` = a, `reg2_addr` = b, `reg3_addr` = c.
- Opcodes:
  - 0 NOP.
  - 1 MOV rc←ra (passthrough).
  - 2 ADD, 3 SUB, 4 SHR, 5 SHL, 6 AND, 7 OR, 8 XOR: rc←ra op rb.
  - 9 NOT rc←~ra.
  - A LD rc←mem[rb].
  - B ST mem[rb]←ra (reg1 read plus passthrough drives `d_bus`).
  - C CMP: if c[0]=0, `cmp_compare` on ra, rb; if c[0]=1, `cmp_load` from ra.
  - D JMP pc←ra (reg1 read plus passthrough plus `pc_load`).
  - E JC: if `f_bus`[b]=1 then pc←ra, else fall through.
  - F HLT.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT.
  - FETCH: IR←`i_bus` at the clock edge; all strobes low; then DECODE.
  - DECODE: assert `reg1_read`/`reg2_read` for the operands the op uses; no writes. Next state: LD/ST go to MEM, HLT goes to HALT, every other op goes to EXEC.
  - EXEC (one cycle): assert the op's read enables, its `lu_*` select, `reg3_write` (ops 1–9), comparator strobe (C), and `pc_load` (D, or E when taken). Every other op asserts `pc_increment`. Then FETCH.
  - MEM: hold `memory_read` (LD) or `memory_write` (ST), the `reg2_read` address, and the ST data path. In the cycle `mem_ready`=1: LD asserts `reg3_write`, both assert `pc_increment` (Mealy on `mem_ready`), then FETCH. While `mem_ready`=0, stay in MEM with no other strobe.
  - HALT: all strobes low, `halted`=1. Only `rst_n` exits.
- Outputs are decoded combinationally from registered state and IR; only the MEM completion strobes depend on `mem_ready`.

## Timing
- Reset (asynchronous): state=FETCH, IR=0x0000, every strobe 0, address outputs 0, `halted`=0. Outputs clear immediately on `rst_n` falling, including mid-MEM; the memory strobe drops in the same cycle.
- First fetch is the first rising edge after `rst_n` deasserts.
- Latency: non-memory ops take 3 cycles (FETCH, DECODE, EXEC). LD/ST take 3 + wait cycles; `mem_ready` already high on MEM entry gives 3 cycles.
- `mem_ready` is ignored outside MEM.
- JC with `f_bus`[b] unknown or 0: no jump.
- HLT: `pc_increment` is never asserted, so PC stays on the HLT address.
- `pc_increment` and `pc_load` are mutually exclusive in every state.

## Test plan
- Reset, then ADD r3←r1+r2 (`i_bus`=0x2123) → DECODE has reg1/reg2 reads; EXEC has `lu_add`, `reg3_write`, `reg3_addr`=3, `pc_increment`; next fetch at cycle 4.
- LD r5←mem[r4] (0xA045) with `mem_ready` low for 2 cycles → `memory_read` high for 3 cycles; `reg3_write` and `pc_increment` only in the ready cycle; 5 cycles total.
- JC 0xE230 with `f_bus`=0x0008, then with `f_bus`=0x0000 → first case `pc_load`=1 with `pc_increment`=0; second case `pc_increment`=1 with `pc_load`=0.
- ST mid-wait (0xB010) with `rst_n` pulsed low asynchronously → `memory_write` falls without a clock edge; FSM restarts at FETCH with IR=0.
- HLT (0xF000) → `halted`=1 from cycle 3; no strobes for 20 cycles; stays halted through `mem_ready` toggling.
- CMP 0xC120, then 0xC101 → first instruction pulses `cmp_compare` once; second pulses `cmp_load` once; both with `pc_increment`.
